front_panel_ctrl: RTL

//  Downstream of front_panel: consumes switches_status[0:24], debounces and edge-detects each switch,
//  and runs the Altair panel commands (EXAMINE, EXAMINE NEXT, DEPOSIT, DEPOSIT NEXT, RESET, SINGLE STEP)
//  as a memory request/ack transaction. Drives CPU run/halt/step/reset. Returns panel_addr/panel_data,

---
 rtl/front_panel_ctrl_pkg.sv | 42 ++++
 rtl/front_panel_ctrl_debounce.sv | 49 ++++
 rtl/front_panel_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/front_panel_ctrl_pkg.sv
// Shared switch map, switch codes and FSM/command enums for the Altair front-panel controller.
package altair_fp_pkg;

  localparam int unsigned NUM_SW      = 25;
  localparam int unsigned SW_POWER    = 16;
  localparam int unsigned SW_STOP_RUN = 17;
  localparam int unsigned SW_STEP     = 18;
  localparam int unsigned SW_EXAMINE  = 19;
  localparam int unsigned SW_DEPOSIT  = 20;
  localparam int unsigned SW_RESET    = 21;
  localparam int unsigned SW_PROTECT  = 22;
  localparam int unsigned SW_AUX1     = 23;
  localparam int unsigned SW_AUX2     = 24;

  localparam logic [1:0] SW_DOWN      = 2'd0;
  localparam logic [1:0] SW_UP        = 2'd1;
  localparam logic [1:0] SW_TOGGLE_UP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_WR_REQ,
    ST_RST_HOLD
  } fp_state_t;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_RESET,
    CMD_EXAM,
    CMD_EXAM_NEXT,
    CMD_DEP,
    CMD_DEP_NEXT,
    CMD_STEP
  } cmd_t;

  // A toggle only fires when it leaves the rest position; it must return there to re-arm.
  function automatic logic armed_edge(input logic [1:0] prev, input logic [1:0] cur,
                                      input logic [1:0] code);
    return (prev == SW_DOWN) && (cur == code);
  endfunction

endpackage

// File: rtl/front_panel_ctrl_debounce.sv
// Per-switch debouncer: a 2-bit switch code is accepted once it has been sampled
// DEBOUNCE_CYCLES times in a row; any change restarts the count.
module switch_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter logic [1:0]  RESET_VALUE     = 2'd0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] code_i,
  output logic [1:0] code_o
);

  localparam int unsigned    CW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES - 1) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

  logic [1:0]    cand_q, cand_d;
  logic [1:0]    out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q counts repeats after the first sample of a new code, so acceptance lands on sample N.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    if (code_i != cand_q) begin
      cand_d = code_i;
      cnt_d  = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      out_d = cand_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cand_q <= RESET_VALUE;
      out_q  <= RESET_VALUE;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
    end
  end

  assign code_o = out_q;

endmodule

// File: rtl/front_panel_ctrl.sv
// Altair front-panel command controller: debounces the panel switches, runs
// EXAMINE/DEPOSIT/STEP/RESET as memory or CPU control actions.
module front_panel_ctrl
  import altair_fp_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned MEM_TIMEOUT     = 255,
  parameter int unsigned RESET_PULSE     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  switches_status [0:24],
  input  logic        cpu_halted,
  output logic        cpu_run,
  output logic        cpu_step,
  output logic        cpu_reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] panel_addr,
  output logic [7:0]  panel_data,
  output logic        busy
);

  localparam int unsigned TMAX = (MEM_TIMEOUT > RESET_PULSE) ? MEM_TIMEOUT : RESET_PULSE;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  logic [1:0]  db [0:NUM_SW-1];
  logic [15:0] sw_word;
  logic        power_on;
  logic        unused_sw;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    switch_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VALUE     ((i == SW_POWER || i == SW_STOP_RUN) ? SW_UP : SW_DOWN)
    ) u_db (
      .clk_i  (clk),
      .rst_i  (reset),
      .code_i (switches_status[i]),
      .code_o (db[i])
    );
  end

  always_comb begin
    for (int unsigned b = 0; b < 16; b++) sw_word[b] = (db[b] == SW_UP);
  end

  assign power_on  = (db[SW_POWER] == SW_UP);
  assign unused_sw = ^{db[SW_PROTECT], db[SW_AUX1], db[SW_AUX2]};

  logic [1:0]  prev_step_q, prev_exam_q, prev_dep_q, prev_rst_q;
  fp_state_t   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0] panel_addr_q, panel_addr_d;
  logic [7:0]  panel_data_q, panel_data_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rst_pend_q, rst_pend_d;
  logic        step_q, step_d;
  logic        cpu_run_q;
  cmd_t        cmd;

  always_comb begin
    cmd = CMD_NONE;
    if (armed_edge(prev_rst_q, db[SW_RESET], SW_TOGGLE_UP))          cmd = CMD_RESET;
    else if (armed_edge(prev_exam_q, db[SW_EXAMINE], SW_TOGGLE_UP))  cmd = CMD_EXAM;
    else if (armed_edge(prev_exam_q, db[SW_EXAMINE], SW_UP))         cmd = CMD_EXAM_NEXT;
    else if (armed_edge(prev_dep_q, db[SW_DEPOSIT], SW_TOGGLE_UP))   cmd = CMD_DEP;
    else if (armed_edge(prev_dep_q, db[SW_DEPOSIT], SW_UP))          cmd = CMD_DEP_NEXT;
    else if (armed_edge(prev_step_q, db[SW_STEP], SW_TOGGLE_UP))     cmd = CMD_STEP;
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    panel_addr_d = panel_addr_q;
    panel_data_d = panel_data_q;
    wdata_d      = wdata_q;
    rst_pend_d   = rst_pend_q;
    step_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (rst_pend_q || cmd == CMD_RESET) begin
          rst_pend_d   = 1'b0;
          panel_addr_d = '0;
          state_d      = ST_RST_HOLD;
        end else if (cpu_halted) begin
          unique case (cmd)
            CMD_EXAM: begin
              panel_addr_d = sw_word;
              state_d      = ST_RD_REQ;
            end
            CMD_EXAM_NEXT: begin
              panel_addr_d = panel_addr_q + 16'd1;
              state_d      = ST_RD_REQ;
            end
            CMD_DEP: begin
              wdata_d = sw_word[7:0];
              state_d = ST_WR_REQ;
            end
            CMD_DEP_NEXT: begin
              panel_addr_d = panel_addr_q + 16'd1;
              wdata_d      = sw_word[7:0];
              state_d      = ST_WR_REQ;
            end
            CMD_STEP: step_d = 1'b1;
            default: ;
          endcase
        end
      end
      ST_RD_REQ, ST_WR_REQ: begin
        if (cmd == CMD_RESET) rst_pend_d = 1'b1;
        if (mem_ack) begin
          panel_data_d = (state_q == ST_RD_REQ) ? mem_rdata : wdata_q;
          state_d      = ST_IDLE;
        end else if (timer_q == TW'(MEM_TIMEOUT - 1)) begin
          panel_data_d = 8'hFF;
          state_d      = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RST_HOLD: begin
        if (cmd == CMD_RESET) rst_pend_d = 1'b1;
        if (timer_q == TW'(RESET_PULSE - 1)) state_d = ST_IDLE;
        else                                 timer_d = timer_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Power off overrides everything: abort without touching the displayed values.
    if (!power_on) begin
      state_d      = ST_IDLE;
      timer_d      = '0;
      rst_pend_d   = 1'b0;
      step_d       = 1'b0;
      panel_addr_d = panel_addr_q;
      panel_data_d = panel_data_q;
      wdata_d      = wdata_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      panel_addr_q <= '0;
      panel_data_q <= '0;
      wdata_q      <= '0;
      rst_pend_q   <= 1'b0;
      step_q       <= 1'b0;
      cpu_run_q    <= 1'b0;
      prev_step_q  <= SW_DOWN;
      prev_exam_q  <= SW_DOWN;
      prev_dep_q   <= SW_DOWN;
      prev_rst_q   <= SW_DOWN;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      panel_addr_q <= panel_addr_d;
      panel_data_q <= panel_data_d;
      wdata_q      <= wdata_d;
      rst_pend_q   <= rst_pend_d;
      step_q       <= step_d;
      cpu_run_q    <= power_on && (db[SW_STOP_RUN] != SW_UP);
      prev_step_q  <= db[SW_STEP];
      prev_exam_q  <= db[SW_EXAMINE];
      prev_dep_q   <= db[SW_DEPOSIT];
      prev_rst_q   <= db[SW_RESET];
    end
  end

  assign cpu_run    = cpu_run_q;
  assign cpu_step   = step_q;
  assign cpu_reset  = !power_on || (state_q == ST_RST_HOLD);
  assign mem_req    = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
  assign mem_we     = (state_q == ST_WR_REQ);
  assign mem_addr   = panel_addr_q;
  assign mem_wdata  = wdata_q;
  assign panel_addr = panel_addr_q;
  assign panel_data = panel_data_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
